cpu_sequencer: RTL

//  Multicycle control FSM that sequences the processor datapath: fetch over SysBus, decode,

---
 rtl/cpu_sequencer.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// Multicycle control sequencer for the processor datapath.
// Walks FETCH -> DECODE -> EXEC [-> MEM [-> WB]] per instruction, with interrupt
// entry at instruction boundaries, a halt state and a memory-timeout trap.
// Owns every datapath strobe and select, and guarantees that at most one of
// PcEn/LrEn/AluEn/MemEn drives SysBus in any cycle.

package opcodes;
   typedef enum logic [2:0] {
      IC_ALU    = 3'd0,
      IC_LOAD   = 3'd1,
      IC_STORE  = 3'd2,
      IC_BRANCH = 3'd3,
      IC_CALL   = 3'd4,
      IC_RET    = 3'd5,
      IC_HALT   = 3'd6,
      IC_NOP    = 3'd7
   } instr_class_e;

   typedef enum logic [1:0] {Pc1, PcAluOut, PcLr, PcInt} pc_sel_e;
   typedef enum logic       {Op1Rd1, Op1Pc}              op1_sel_e;
   typedef enum logic       {Op2Rd2, Op2Imm}             op2_sel_e;
   typedef enum logic       {WdAlu, WdSys}               wd_sel_e;
   typedef enum logic       {LrPc, LrAlu}                lr_sel_e;
endpackage

module cpu_sequencer
   import opcodes::*;
#(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [2:0] InstrClass,
   input  logic       BranchTaken,
   input  logic       MemAck,
   input  logic       IntReq,
   output logic       MemReq,
   output logic       MemWrite,
   output logic       IntAck,
   output logic       BusErr,
   output logic       Halted,
   output logic       IrWe,
   output logic       PcWe,
   output logic       PcEn,
   output logic       LrWe,
   output logic       LrEn,
   output logic       AluWe,
   output logic       AluEn,
   output logic       RegWe,
   output logic       MemEn,
   output pc_sel_e    PcSel,
   output op1_sel_e   Op1Sel,
   output op2_sel_e   Op2Sel,
   output wd_sel_e    WdSel,
   output lr_sel_e    LrSel
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_INT, S_HALT, S_TRAP
   } state_e;

   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   state_e       state_q,    state_d;
   logic         int_en_q,   int_en_d;
   logic         bus_err_q,  bus_err_d;
   logic         is_store_q, is_store_d;
   logic [7:0]   wait_cnt_q, wait_cnt_d;

   instr_class_e instr_class;
   logic         int_take;
   logic         mem_wait;
   logic         timeout;
   state_e       boundary_state;

   assign instr_class    = instr_class_e'(InstrClass);
   // An instruction boundary diverts to interrupt entry when one is pending and enabled.
   assign int_take       = IntReq & int_en_q;
   assign boundary_state = int_take ? S_INT : S_FETCH;
   // MemReq is high in both FETCH and MEM, so an un-acked cycle there is a wait cycle.
   assign mem_wait       = ((state_q == S_FETCH) || (state_q == S_MEM)) && !MemAck;
   // MemAck arriving in the limit cycle clears mem_wait, so the ack wins over the timeout.
   assign timeout        = mem_wait && (wait_cnt_q == WAIT_LIMIT);

   // State register and sequencer bookkeeping, synchronous reset.
   always_ff @(posedge Clock) begin
      // NOTE: non-blocking assignments here so every flop samples the pre-edge value of every other flop.
      if (Reset) begin
         state_q    <= S_FETCH;
         int_en_q   <= 1'b1;
         bus_err_q  <= 1'b0;
         is_store_q <= 1'b0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         int_en_q   <= int_en_d;
         bus_err_q  <= bus_err_d;
         is_store_q <= is_store_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Next-state logic: instruction flow, interrupt enable, wait counter and timeout trap.
   always_comb begin
      // NOTE: every variable gets a default first so no path through the case infers a latch.
      state_d    = state_q;
      int_en_d   = int_en_q;
      bus_err_d  = bus_err_q;
      is_store_d = is_store_q;
      wait_cnt_d = '0;
      if (mem_wait && !timeout) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end

      case (state_q)
         S_FETCH: begin
            if (MemAck) state_d = S_DECODE;
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            case (instr_class)
               IC_LOAD: begin
                  is_store_d = 1'b0;
                  state_d    = S_MEM;
               end
               IC_STORE: begin
                  is_store_d = 1'b1;
                  state_d    = S_MEM;
               end
               IC_RET: begin
                  // Re-enable takes effect from the next boundary onwards.
                  int_en_d = 1'b1;
                  state_d  = boundary_state;
               end
               IC_HALT: state_d = S_HALT;
               default: state_d = boundary_state;
            endcase
         end
         S_MEM: begin
            if (MemAck) state_d = is_store_q ? boundary_state : S_WB;
         end
         S_WB: state_d = boundary_state;
         S_INT: begin
            int_en_d = 1'b0;
            state_d  = S_FETCH;
         end
         S_HALT: begin
            if (int_take) state_d = S_INT;
         end
         S_TRAP: state_d = S_TRAP;
      endcase

      if (timeout) begin
         bus_err_d = 1'b1;
         state_d   = S_TRAP;
      end
   end

   // Datapath strobes and selects; all held idle while Reset is asserted.
   always_comb begin
      MemReq   = 1'b0;
      MemWrite = 1'b0;
      IntAck   = 1'b0;
      IrWe     = 1'b0;
      PcWe     = 1'b0;
      PcEn     = 1'b0;
      LrWe     = 1'b0;
      LrEn     = 1'b0;
      AluWe    = 1'b0;
      AluEn    = 1'b0;
      RegWe    = 1'b0;
      MemEn    = 1'b0;
      PcSel    = Pc1;
      Op1Sel   = Op1Rd1;
      Op2Sel   = Op2Rd2;
      WdSel    = WdAlu;
      LrSel    = LrPc;

      if (!Reset) begin
         case (state_q)
            S_FETCH: begin
               PcEn   = 1'b1;
               MemReq = 1'b1;
               if (MemAck) begin
                  IrWe = 1'b1;
                  PcWe = 1'b1;
               end
            end
            S_EXEC: begin
               case (instr_class)
                  IC_ALU: RegWe = 1'b1;
                  IC_LOAD, IC_STORE: AluWe = 1'b1;
                  IC_BRANCH: begin
                     if (BranchTaken) begin
                        PcSel  = PcAluOut;
                        Op1Sel = Op1Pc;
                        Op2Sel = Op2Imm;
                        PcWe   = 1'b1;
                     end
                  end
                  IC_CALL: begin
                     LrWe  = 1'b1;
                     LrSel = LrPc;
                     PcWe  = 1'b1;
                     PcSel = PcAluOut;
                  end
                  IC_RET: begin
                     PcSel = PcLr;
                     PcWe  = 1'b1;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               AluEn    = 1'b1;
               MemReq   = 1'b1;
               MemWrite = is_store_q;
            end
            S_WB: begin
               MemEn = 1'b1;
               WdSel = WdSys;
               RegWe = 1'b1;
            end
            S_INT: begin
               LrWe   = 1'b1;
               LrSel  = LrPc;
               PcSel  = PcInt;
               PcWe   = 1'b1;
               IntAck = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign BusErr = bus_err_q;
   assign Halted = (state_q == S_HALT);

endmodule
